// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit for the multi-cycle NPC core.
//
// Holds the architectural PC. Issues one 32-bit read per instruction on an AR/R read
// channel and hands the fetched word and its PC to the decoder through a valid/ready
// handshake. Downstream redirects replace the PC. A fetch that is already in flight
// when a redirect arrives is marked stale and its response is discarded.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   araddr_o/arvalid_o    read request (address, valid); arready_i accepts it
//   rdata_i/rresp_i       returned word and response code (non-zero = fetch fault)
//   rvalid_i/rready_o     read response handshake
//   inst_o/pc_o           fetched instruction and its PC
//   inst_err_o            the instruction came from a faulting response
//   inst_valid_o          inst_o/pc_o/inst_err_o valid; inst_ready_i consumes them
//   redirect_valid_i      one-cycle pulse; the next fetch comes from redirect_target_i
module ysyx_22041211_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_err_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e      r_state, w_state_d;
    logic [31:0] r_pc, w_pc_d;
    logic [31:0] r_req_addr, w_req_addr_d;
    logic        r_kill, w_kill_d;
    logic [31:0] r_inst, w_inst_d;
    logic [31:0] r_pc_out, w_pc_out_d;
    logic        r_inst_err, w_inst_err_d;
    logic [31:0] w_pc_inc;

    // Modulo 2^32: the top word wraps to zero.
    assign w_pc_inc = r_pc + 32'd4;

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_req_addr_d = r_req_addr;
        w_kill_d     = r_kill;
        w_inst_d     = r_inst;
        w_pc_out_d   = r_pc_out;
        w_inst_err_d = r_inst_err;

        unique case (r_state)
            StIdle: begin
                w_state_d = StReq;
                if (redirect_valid_i) begin
                    w_pc_d       = redirect_target_i;
                    w_req_addr_d = redirect_target_i;
                end else begin
                    w_req_addr_d = r_pc;
                end
            end
            StReq: begin
                // The request stays up until accepted; a redirect only marks it stale.
                if (redirect_valid_i) begin
                    w_pc_d   = redirect_target_i;
                    w_kill_d = 1'b1;
                end
                if (arready_i) begin
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (rvalid_i) begin
                    if (redirect_valid_i) begin
                        // Response is stale by definition; refetch straight from the target.
                        w_pc_d       = redirect_target_i;
                        w_req_addr_d = redirect_target_i;
                        w_kill_d     = 1'b0;
                        w_state_d    = StReq;
                    end else if (r_kill) begin
                        w_kill_d     = 1'b0;
                        w_req_addr_d = r_pc;
                        w_state_d    = StReq;
                    end else begin
                        w_inst_d     = rdata_i;
                        w_pc_out_d   = r_req_addr;
                        w_inst_err_d = (rresp_i != 2'b00);
                        w_state_d    = StHold;
                    end
                end else if (redirect_valid_i) begin
                    w_pc_d   = redirect_target_i;
                    w_kill_d = 1'b1;
                end
            end
            StHold: begin
                // Redirect wins over the sequential increment, even on a handshake.
                if (redirect_valid_i) begin
                    w_pc_d       = redirect_target_i;
                    w_req_addr_d = redirect_target_i;
                    w_state_d    = StReq;
                end else if (inst_ready_i) begin
                    w_pc_d       = w_pc_inc;
                    w_req_addr_d = w_pc_inc;
                    w_state_d    = StReq;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_kill     <= 1'b0;
            r_inst     <= 32'h0000_0013;
            r_pc_out   <= RESET_PC;
            r_inst_err <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_req_addr <= w_req_addr_d;
            r_kill     <= w_kill_d;
            r_inst     <= w_inst_d;
            r_pc_out   <= w_pc_out_d;
            r_inst_err <= w_inst_err_d;
        end
    end

    // All outputs come from registers only.
    assign araddr_o     = r_req_addr;
    assign arvalid_o    = (r_state == StReq);
    assign rready_o     = (r_state == StWait);
    assign inst_valid_o = (r_state == StHold);
    assign inst_o       = r_inst;
    assign pc_o         = r_pc_out;
    assign inst_err_o   = r_inst_err;

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Bench for ysyx_22041211_ifu: a memory/decoder model driven on the falling edge, and
// a monitor that pops expected AR addresses and instructions from scoreboard queues.
module tb_ysyx_22041211_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i = 1'b0;
    logic [31:0] rdata_i = 32'h0;
    logic [1:0]  rresp_i = 2'b00;
    logic        rvalid_i = 1'b0;
    logic        rready_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_err_o;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_target_i = 32'h0;

    ysyx_22041211_ifu #(
        .RESET_PC(RST_PC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .araddr_o          (araddr_o),
        .arvalid_o         (arvalid_o),
        .arready_i         (arready_i),
        .rdata_i           (rdata_i),
        .rresp_i           (rresp_i),
        .rvalid_i          (rvalid_i),
        .rready_o          (rready_o),
        .inst_o            (inst_o),
        .pc_o              (pc_o),
        .inst_err_o        (inst_err_o),
        .inst_valid_o      (inst_valid_o),
        .inst_ready_i      (inst_ready_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [31:0] exp_ar[$];
    logic [64:0] exp_in[$];
    int          hs_cyc[$];

    // Model configuration, written by the main sequence while the DUT is in reset.
    int          ar_stall = 0;
    int          dec_stall = 0;
    int          rsp_wait = 0;
    logic [31:0] err_addr = 32'h0000_0001;
    bit          stale_rsp = 1'b0;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [64:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                       input logic err);
        return {pc, inst, err};
    endfunction

    // Memory and decoder model. Works at negedge+1 so the main sequence's negedge
    // writes (reset, redirect, config) have settled.
    bit          p_arhs = 1'b0;
    bit          p_rhs = 1'b0;
    logic [31:0] p_araddr = 32'h0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;

    initial forever begin
        @(negedge clk);
        #1;
        if (p_rhs) begin
            pend      = 1'b0;
            stale_rsp = 1'b0;
        end
        if (p_arhs) begin
            pend      = 1'b1;
            pend_addr = p_araddr;
            pend_cnt  = rsp_wait;
            stale_rsp = 1'b0;
        end
        if (!rst_n) pend = 1'b0;

        if (arvalid_o && ar_stall > 0) begin
            arready_i = 1'b0;
            ar_stall--;
        end else begin
            arready_i = 1'b1;
        end

        if (stale_rsp) begin
            rvalid_i = 1'b1;
            rdata_i  = 32'hDEAD_BEEF;
            rresp_i  = 2'b00;
        end else if (pend) begin
            if (pend_cnt > 0) begin
                pend_cnt--;
                rvalid_i = 1'b0;
            end else begin
                rvalid_i = 1'b1;
                rdata_i  = pend_addr;
                rresp_i  = (pend_addr == err_addr) ? 2'b10 : 2'b00;
            end
        end else begin
            rvalid_i = 1'b0;
        end

        if (inst_valid_o && dec_stall > 0) begin
            inst_ready_i = 1'b0;
            dec_stall--;
        end else begin
            inst_ready_i = 1'b1;
        end

        p_arhs   = arvalid_o && arready_i && rst_n;
        p_araddr = araddr_o;
        p_rhs    = rvalid_i && rready_o && rst_n;
    end

    // Monitor: compares at negedge+2, after all inputs for the next edge are settled.
    bit          m_ar_wait = 1'b0;
    logic [31:0] m_addr = 32'h0;
    bit          m_hold = 1'b0;
    logic [64:0] m_out = 65'h0;

    initial forever begin
        @(negedge clk);
        #2;
        cyc++;
        if (m_ar_wait) check("ar_stable", {arvalid_o, araddr_o}, {1'b1, m_addr});
        if (m_hold) check("hold_stable", {inst_valid_o, pc_o, inst_o, inst_err_o}, {1'b1, m_out});
        if (rst_n && arvalid_o && arready_i && exp_ar.size() > 0)
            check("ar_addr", araddr_o, exp_ar.pop_front());
        if (rst_n && inst_valid_o && inst_ready_i && !redirect_valid_i && exp_in.size() > 0) begin
            check("inst", {pc_o, inst_o, inst_err_o}, exp_in.pop_front());
            hs_cyc.push_back(cyc);
        end
        m_ar_wait = rst_n && arvalid_o && !arready_i;
        m_addr    = araddr_o;
        m_hold    = rst_n && inst_valid_o && !inst_ready_i && !redirect_valid_i;
        m_out     = {pc_o, inst_o, inst_err_o};
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n            = 1'b0;
        redirect_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ctrl", {arvalid_o, rready_o, inst_valid_o, inst_err_o}, 4'b0000);
        check("rst_inst", inst_o, 32'h0000_0013);
        check("rst_pc", pc_o, RST_PC);
        hs_cyc.delete();
    endtask

    task automatic wait_drain(input string nm);
        int k;
        k = 0;
        while ((exp_ar.size() > 0 || exp_in.size() > 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (exp_ar.size() > 0 || exp_in.size() > 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d AR and %0d inst still pending, required 0", nm,
                     exp_ar.size(), exp_in.size());
            exp_ar.delete();
            exp_in.delete();
        end
    endtask

    // Wait (bounded) for the WAIT state of a given fetch address.
    task automatic wait_for_wait(input logic [31:0] addr, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (rready_o && araddr_o == addr) ok = 1'b1;
        end
    endtask

    // Wait (bounded) for the HOLD state presenting a given PC.
    task automatic wait_for_hold(input logic [31:0] pc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (inst_valid_o && pc_o == pc) ok = 1'b1;
        end
    endtask

    task automatic push_pair(input logic [31:0] a);
        exp_ar.push_back(a);
        exp_in.push_back(mk(a, a, 1'b0));
    endtask

    task automatic pulse_redirect(input logic [31:0] tgt);
        redirect_valid_i  = 1'b1;
        redirect_target_i = tgt;
        @(negedge clk);
        redirect_valid_i  = 1'b0;
    endtask

    initial begin
        bit ok;

        // Basic sequential fetch with zero-wait memory and an always-ready decoder.
        do_reset();
        push_pair(32'h8000_0000);
        push_pair(32'h8000_0004);
        push_pair(32'h8000_0008);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_ar", {arvalid_o, araddr_o}, {1'b1, RST_PC});
        wait_drain("basic");
        check("hs_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            check("gap01", hs_cyc[1] - hs_cyc[0], 3);
            check("gap12", hs_cyc[2] - hs_cyc[1], 3);
        end

        // AR stall of 4 cycles, then decoder stall of 5 cycles in HOLD.
        do_reset();
        ar_stall  = 4;
        dec_stall = 5;
        push_pair(32'h8000_0000);
        push_pair(32'h8000_0004);
        rst_n = 1'b1;
        wait_drain("stall");

        // Redirect while waiting on a slow response: the stale word is discarded.
        do_reset();
        rsp_wait = 2;
        push_pair(32'h8000_0000);
        push_pair(32'h8000_0004);
        exp_ar.push_back(32'h8000_0008);
        push_pair(32'h8000_0100);
        exp_ar.push_back(32'h8000_0104);
        rst_n = 1'b1;
        wait_for_wait(32'h8000_0008, ok);
        check("kill_reach", ok, 1'b1);
        pulse_redirect(32'h8000_0100);
        wait_drain("kill");

        // Redirect in the same cycle as the response.
        do_reset();
        rsp_wait = 0;
        push_pair(32'h8000_0000);
        push_pair(32'h8000_0004);
        exp_ar.push_back(32'h8000_0008);
        push_pair(32'h8000_0180);
        exp_ar.push_back(32'h8000_0184);
        rst_n = 1'b1;
        wait_for_wait(32'h8000_0008, ok);
        check("same_reach", ok, 1'b1);
        pulse_redirect(32'h8000_0180);
        wait_drain("same");

        // Redirect in HOLD together with inst_ready_i: target wins over pc+4.
        do_reset();
        push_pair(32'h8000_0000);
        exp_ar.push_back(32'h8000_0004);
        push_pair(32'h8000_0200);
        exp_ar.push_back(32'h8000_0204);
        rst_n = 1'b1;
        wait_for_hold(32'h8000_0004, ok);
        check("hold_reach", ok, 1'b1);
        pulse_redirect(32'h8000_0200);
        check("hold_drop", inst_valid_o, 1'b0);
        wait_drain("hold_redir");

        // Faulting response on 0x80000004 is delivered with inst_err_o set.
        do_reset();
        err_addr = 32'h8000_0004;
        exp_ar.push_back(32'h8000_0000);
        exp_ar.push_back(32'h8000_0004);
        exp_ar.push_back(32'h8000_0008);
        exp_in.push_back(mk(32'h8000_0000, 32'h8000_0000, 1'b0));
        exp_in.push_back(mk(32'h8000_0004, 32'h8000_0004, 1'b1));
        exp_in.push_back(mk(32'h8000_0008, 32'h8000_0008, 1'b0));
        rst_n = 1'b1;
        wait_drain("fault");

        // Reset during WAIT; a late response stays on the bus and must be ignored.
        do_reset();
        err_addr = 32'h0000_0001;
        rsp_wait = 3;
        push_pair(32'h8000_0000);
        exp_ar.push_back(32'h8000_0004);
        rst_n = 1'b1;
        wait_drain("pre_rst");
        wait_for_wait(32'h8000_0004, ok);
        check("rst_reach", ok, 1'b1);
        rst_n     = 1'b0;
        stale_rsp = 1'b1;
        do_reset();
        rsp_wait = 0;
        push_pair(32'h8000_0000);
        push_pair(32'h8000_0004);
        rst_n = 1'b1;
        wait_drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ysyx_22041211_ifu.md
# ysyx_22041211_ifu

Instruction fetch unit for the multi-cycle NPC core. Holds the architectural PC and issues one 32-bit read per instruction on an AXI-lite-style read channel (AR/R). Presents the fetched word plus its PC to the decoder via a valid/ready handshake. Accepts redirects (taken branch, jal/jalr, ecall/mret target) from downstream and discards any stale in-flight fetch.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC value after reset.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `araddr_o`  out  32  fetch address.
- `arvalid_o`  out  1  read request valid.
- `arready_i`  in  1  memory accepts request.
- `rdata_i`  in  32  returned instruction word.
- `rresp_i`  in  2  response code; 2'b00 = OKAY, anything else = fetch fault.
- `rvalid_i`  in  1  response valid.
- `rready_o`  out  1  IFU accepts response.
- `inst_o`  out  32  instruction to decoder.
- `pc_o`  out  32  PC of `inst_o`.
- `inst_err_o`  out  1  `inst_o` came from a faulting response; qualified by `inst_valid_o`.
- `inst_valid_o`  out  1  `inst_o`/`pc_o` valid.
- `inst_ready_i`  in  1  decoder consumes the instruction.
- `redirect_valid_i`  in  1  one-cycle pulse: next fetch comes from `redirect_target_i`.
- `redirect_target_i`  in  32  redirect PC.

## Operation
- Registers: `pc` (next fetch PC), `req_addr` (address of the outstanding request), `kill` (in-flight fetch is stale), output latches for `inst_o`/`pc_o`/`inst_err_o`, 2-bit state.
- States: IDLE, REQ, WAIT, HOLD.
  - IDLE: entered on reset. Next cycle, `req_addr <= pc` and go to REQ.
  - REQ: `arvalid_o=1`, `araddr_o=req_addr`. Both stay stable until `arready_i`. On `arready_i`, go to WAIT.
  - WAIT: `rready_o=1`. On `rvalid_i`:
    - If `kill=1`: drop the data, clear `kill`, set `req_addr <= pc`, go to REQ.
    - Otherwise: latch `inst_o <= rdata_i`, `pc_o <= req_addr`, `inst_err_o <= (rresp_i != 0)`, go to HOLD.
  - HOLD: `inst_valid_o=1`. Outputs are stable until `inst_ready_i`. On handshake: `pc <= pc + 4`, `req_addr <= pc + 4`, go to REQ.
- Redirect handling (`redirect_valid_i=1`):
  - IDLE: `pc <= target`. The first fetch uses the target.
  - REQ or WAIT: `pc <= target`, `kill <= 1`. The AR request already issued is not withdrawn; its response is discarded in WAIT.
  - HOLD: `pc <= target`, `req_addr <= target`, drop the held instruction (`inst_valid_o` low next cycle), go to REQ. This applies with or without `inst_ready_i`; redirect has priority over the +4 increment.
- Redirect in WAIT in the same cycle as `rvalid_i`: the response is discarded, `req_addr <= target`, go to REQ, `kill` stays 0.
- Misaligned targets (bits [1:0] != 0) are passed to memory unchanged. Alignment checking belongs to the execute stage.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- Fault responses are still delivered to the decoder, with `inst_err_o=1`. The PC then advances normally unless redirected.

## Timing
- Reset values (the cycle after a sampled `rst_n=0`):
  - state = IDLE, `pc` = `req_addr` = `RESET_PC`, `kill` = 0.
  - `arvalid_o` = `rready_o` = `inst_valid_o` = 0.
  - `inst_o` = 32'h0000_0013 (nop), `pc_o` = `RESET_PC`, `inst_err_o` = 0.
- Reset mid-operation: immediate return to IDLE. An outstanding response arriving later is ignored because `rready_o=0` in IDLE; the memory model must tolerate this.
- First `arvalid_o` appears in the 2nd cycle after `rst_n` rises.
- Zero-wait memory (`arready_i`=1; `rvalid_i` the cycle after AR handshake): 3 cycles per instruction (REQ, WAIT, HOLD) when the decoder is always ready.
- `araddr_o`, `arvalid_o`, `rready_o` and `inst_valid_o` are decoded from registered state only. There is no combinational path from any input to any output.

## Test plan
- Reset release, always-ready zero-wait memory returning word = address → AR addresses 0x80000000, 0x80000004, 0x80000008; `inst_valid_o` every 3rd cycle; `pc_o` = `inst_o`.
- `arready_i` held low 4 cycles, then decoder stalls 5 cycles in HOLD → `araddr_o` and `arvalid_o` stable through the AR stall; `inst_o`/`pc_o` stable through the HOLD stall; no duplicate or skipped PC.
- Redirect to 0x80000100 while in WAIT for 0x80000008 → response for 0x80000008 never shows `inst_valid_o`; next AR = 0x80000100.
- Redirect to 0x80000200 in HOLD together with `inst_ready_i` → next AR = 0x80000200, not `pc_o`+4.
- `rresp_i`=2'b10 on fetch of 0x80000004 → `inst_valid_o` with `inst_err_o=1`, `pc_o`=0x80000004; next fetch 0x80000008 has `inst_err_o=0`.
- `rst_n` asserted low during WAIT, then released → outputs at reset values; fetch restarts at `RESET_PC`; the late `rvalid_i` is not accepted.
